// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS execute-stage
//               multiply/divide unit.
//               - muldiv_op_t : encoding of the 3-bit mul/div operation field
//               - md_state_t  : sequencing states of the iterative unit
//               - MD_ITER     : iterations per mul/div (one bit per cycle)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Unsigned iterative engine, one bit per i_step cycle.
//               Multiply: shift-add; o_acc ends as the 2*WIDTH-bit product.
//               Divide  : restoring shift-subtract; o_acc ends as
//                         {remainder, quotient}.
// Ports       : clk, reset   - clock, async active-high reset
//               i_load       - initialise o_acc={0,i_init_lo}, counter=0
//               i_step       - perform one iteration
//               i_is_div     - 1: divide step, 0: multiply step
//               i_init_lo    - multiplier (mul) or dividend (div)
//               i_operand    - multiplicand (mul) or divisor (div)
//               o_acc        - 2*WIDTH-bit accumulator
//               o_last       - current step is the final iteration
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_init_lo,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [CW-1:0]      r_count;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_next;

  // Multiply: add multiplicand into the upper half when the LSB of the
  // multiplier (low half) is set, then shift the whole thing right with carry.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                   {1'b0, (r_acc[0] ? r_operand : {WIDTH{1'b0}})};

  // Divide: partial remainder shifted left by one with the next dividend bit.
  assign w_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge    = (w_trial >= {1'b0, r_operand});
  assign w_diff  = w_trial - {1'b0, r_operand};

  always_comb begin
    w_next = r_acc;
    if (i_is_div) begin
      if (w_ge) w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else      w_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_operand <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_acc     <= {{WIDTH{1'b0}}, i_init_lo};
      r_operand <= i_operand;
      r_count   <= '0;
    end else if (i_step) begin
      r_acc     <= w_next;
      r_count   <= r_count + 1'b1;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_count == CW'(WIDTH - 1));

endmodule : muldiv_core
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO with
//               architectural HI/LO registers. Signs are stripped on entry,
//               the unsigned core runs WIDTH steps, signs are restored in FIX.
// Ports       : clk, reset - clock, async active-high reset
//               start, op  - request and operation (sampled when busy=0)
//               a, b       - rs / rt operands
//               busy       - iterative operation in progress
//               done       - one-cycle pulse after HI/LO update
//               hi, lo     - HI / LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          r_state;
  logic               r_is_div;
  logic               r_neg_res;   // product / quotient negated
  logic               r_neg_rem;   // remainder negated (dividend negative)
  logic               r_div0;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_load;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_accept = start && (r_state == IDLE);
  assign w_load   = w_accept && !op[2];
  // op[0]=0 selects the signed flavours (MULT, DIV)
  assign w_signed = !op[0];
  assign w_neg_a  = w_signed && a[WIDTH-1];
  assign w_neg_b  = w_signed && b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? (~a + 1'b1) : a;
  assign w_mag_b  = w_neg_b ? (~b + 1'b1) : b;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_step    (r_state == RUN),
    .i_is_div  (r_is_div),
    .i_init_lo (op[1] ? w_mag_a : w_mag_b),
    .i_operand (op[1] ? w_mag_b : w_mag_a),
    .o_acc     (w_acc),
    .o_last    (w_last)
  );

  assign w_prod = r_neg_res ? (~w_acc + 1'b1) : w_acc;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        // Divide by zero reports the raw dividend and an all-ones quotient
        w_res_hi = r_a_orig;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg_res ? (~w_acc[WIDTH-1:0] + 1'b1) : w_acc[WIDTH-1:0];
        w_res_hi = r_neg_rem ? (~w_acc[2*WIDTH-1:WIDTH] + 1'b1)
                             : w_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_a_orig  <= '0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                r_is_div  <= op[1];
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= op[1] && w_neg_a;
                r_div0    <= op[1] && (b == '0);
                r_a_orig  <= a;
                r_state   <= RUN;
              end
              MD_MTHI: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              MD_MTLO: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed corner cases
//               plus randomized operations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_cmp = 0;
  int           n_mis = 0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Architectural reference: results straight from integer arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; {m_hi, m_lo} = p; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = up; end
      3'd2, 3'd3: begin
        if (y == 0) begin
          m_lo = '1;
          m_hi = x;
        end else if (o == 3'd2) begin
          m_lo = 32'(sx / sy);
          m_hi = 32'(sx % sy);
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Entered #1 after a clock edge with the unit idle. inj>0 pulses an
  // extra DIVU start during the busy window at that busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit idle_after, input int inj);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    model(o, x, y);
    if (!o[2]) begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        if (n == inj) begin
          start = 1'b1; op = 3'b011; a = 32'd7; b = 32'd2;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk($sformatf("busy_cycles op%0d", o), 64'(n), 64'd33);
    end else begin
      chk($sformatf("busy_low op%0d", o), {63'd0, busy}, 64'd0);
    end
    chk($sformatf("done op%0d", o), {63'd0, done}, {63'd0, (o[2:1] != 2'b11)});
    chk($sformatf("hi op%0d a=%h b=%h", o, x, y), {32'd0, hi}, {32'd0, m_hi});
    chk($sformatf("lo op%0d a=%h b=%h", o, x, y), {32'd0, lo}, {32'd0, m_lo});
    if (idle_after) begin
      @(posedge clk); #1;
      chk("done_single", {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    int           sel;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("done_after_rst", {63'd0, done}, 64'd0);

    // Directed cases
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1, 0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1, 0);
    do_op(3'd3, 32'd100, 32'd0, 1, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1, 0);
    do_op(3'd4, 32'h1234_5678, 32'd0, 1, 0);
    do_op(3'd5, 32'hCAFE_BABE, 32'd0, 1, 0);
    do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1, 0);

    // Start during busy is ignored; then a back-to-back start in the done cycle
    do_op(3'd1, 32'h0001_2345, 32'h0006_789A, 0, 10);
    do_op(3'd3, 32'd1000, 32'd7, 1, 0);

    // Asynchronous reset mid-RUN
    start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_hi",   {32'd0, hi}, 64'd0);
    chk("async_lo",   {32'd0, lo}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_post_rst", {63'd0, done}, 64'd0);
    end
    do_op(3'd3, 32'd9, 32'd4, 1, 0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      ro  = 3'($urandom_range(0, 7));
      rx  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       ry = 32'd0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = 32'($urandom_range(1, 15));
        3:       begin ry = $urandom; rx = 32'h8000_0000; end
        default: ry = $urandom;
      endcase
      do_op(ro, rx, ry, bit'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire
